// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: reads an NUM_OF_WORDS-word message from a synchronous
// SRAM, appends SHA-256 padding (delimiter, zero fill, 64-bit bit length) and
// offers the result as 512-bit blocks over a valid/ready handshake.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         mem_clk,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic [7:0]   blk_index,
  output logic         busy,
  output logic         done
);

  // Block count ceil((N+3)/16): room for the delimiter word and two length words.
  localparam int          NB           = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [15:0] N_W          = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LEN_WORD_IDX = 16'(16 * NB - 1);
  localparam logic [31:0] BIT_LEN      = 32'(NUM_OF_WORDS * 32);
  localparam logic [7:0]  LAST_IDX     = 8'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_OFFER, S_DONE} state_t;

  state_t         r_state;
  logic [15:0]    r_base;
  logic [15:0]    r_mem_addr;
  logic [511:0]   r_blk_data;
  logic           r_blk_valid;
  logic           r_blk_last;
  logic [7:0]     r_blk_index;
  logic           r_busy;
  logic           r_done;

  // Issue counter: next slot whose address/source goes out while in FILL.
  logic [3:0]     r_slot;
  logic           r_issue_en;

  // Stage 1 travels with mem_addr; stage 2 lines up with mem_read_data.
  logic           r_s1_valid, r_s1_mem;
  logic [3:0]     r_s1_slot;
  logic [31:0]    r_s1_pad;
  logic           r_s2_valid, r_s2_mem;
  logic [3:0]     r_s2_slot;
  logic [31:0]    r_s2_pad;

  logic           w_handshake;
  logic           w_iss_en;
  logic [7:0]     w_iss_index;
  logic [3:0]     w_iss_slot;
  logic [15:0]    w_iss_base;
  logic [15:0]    w_iss_w;
  logic           w_iss_mem;
  logic [31:0]    w_iss_pad;
  logic [15:0]    w_iss_addr;
  logic [31:0]    w_cap_word;
  logic [8:0]     w_cap_lsb;

  assign mem_clk   = clk;
  assign mem_addr  = r_mem_addr;
  assign blk_data  = r_blk_data;
  assign blk_valid = r_blk_valid;
  assign blk_last  = r_blk_last;
  assign blk_index = r_blk_index;
  assign busy      = r_busy;
  assign done      = r_done;

  // Captured word: SRAM data for message slots, otherwise the pad constant.
  assign w_cap_word = r_s2_mem ? mem_read_data : r_s2_pad;
  // Slot 0 sits in the top word, so the bit offset is (15 - slot) * 32.
  assign w_cap_lsb  = {~r_s2_slot, 5'b00000};

  // Decide which word (if any) is requested this cycle and where it comes from.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_handshake = (r_state == S_OFFER) && r_blk_valid && blk_ready;
    w_iss_en    = 1'b0;
    w_iss_index = r_blk_index;
    w_iss_slot  = r_slot;
    w_iss_base  = r_base;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_iss_en    = 1'b1;
          w_iss_index = 8'd0;
          w_iss_slot  = 4'd0;
          w_iss_base  = message_addr;
        end
      end
      S_FILL:  w_iss_en = r_issue_en;
      S_OFFER: begin
        if (w_handshake && !r_blk_last) begin
          w_iss_en    = 1'b1;
          w_iss_index = r_blk_index + 8'd1;
          w_iss_slot  = 4'd0;
        end
      end
      default: w_iss_en = 1'b0;
    endcase
    w_iss_w    = {4'd0, w_iss_index, w_iss_slot};
    w_iss_mem  = (w_iss_w < N_W);
    w_iss_pad  = (w_iss_w == N_W)          ? 32'h8000_0000 :
                 (w_iss_w == LEN_WORD_IDX) ? BIT_LEN       : 32'h0000_0000;
    w_iss_addr = w_iss_base + w_iss_w;
  end

  // Read pipeline: issue address and source select, then delay the select to meet the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_addr <= '0;
      r_slot     <= '0;
      r_issue_en <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_mem   <= 1'b0;
      r_s1_slot  <= '0;
      r_s1_pad   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mem   <= 1'b0;
      r_s2_slot  <= '0;
      r_s2_pad   <= '0;
    end else begin
      // NOTE: non-blocking so stage 2 takes stage 1's value from before this edge.
      r_s1_valid <= w_iss_en;
      r_s1_mem   <= w_iss_mem;
      r_s1_slot  <= w_iss_slot;
      r_s1_pad   <= w_iss_pad;
      r_s2_valid <= r_s1_valid;
      r_s2_mem   <= r_s1_mem;
      r_s2_slot  <= r_s1_slot;
      r_s2_pad   <= r_s1_pad;
      if (w_iss_en && w_iss_mem) begin
        r_mem_addr <= w_iss_addr;
      end
      if (w_iss_en) begin
        r_slot     <= w_iss_slot + 4'd1;
        r_issue_en <= (w_iss_slot != 4'd15);
      end
    end
  end

  // Control FSM: fill the block register, offer it, then pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_blk_data  <= '0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_blk_index <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base      <= message_addr;
            r_blk_index <= 8'd0;
            r_blk_last  <= (LAST_IDX == 8'd0);
            r_blk_data  <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (r_s2_valid) begin
            r_blk_data[w_cap_lsb +: 32] <= w_cap_word;
            if (r_s2_slot == 4'd15) begin
              r_blk_valid <= 1'b1;
              r_state     <= S_OFFER;
            end
          end
        end
        S_OFFER: begin
          if (w_handshake) begin
            r_blk_valid <= 1'b0;
            if (r_blk_last) begin
              r_state <= S_DONE;
            end else begin
              r_blk_index <= r_blk_index + 8'd1;
              r_blk_last  <= ((r_blk_index + 8'd1) == LAST_IDX);
              r_blk_data  <= '0;
              r_state     <= S_FILL;
            end
          end
        end
        S_DONE: begin
          // First DONE cycle raises done; the second drops done and busy together.
          if (!r_done) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder: three instances (N = 20, 13, 14) share one
// SRAM image; blocks are compared against a word-by-word padding model.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start_a        [NI];
  logic [15:0]  message_addr_a [NI];
  logic         mem_clk_a      [NI];
  logic [15:0]  mem_addr_a     [NI];
  logic         blk_valid_a    [NI];
  logic         blk_ready_a    [NI];
  logic [511:0] blk_data_a     [NI];
  logic         blk_last_a     [NI];
  logic [7:0]   blk_index_a    [NI];
  logic         busy_a         [NI];
  logic         done_a         [NI];

  logic [31:0]  mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  logic [511:0] first_blk;
  logic [511:0] last_blk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NW = (g == 0) ? 20 : ((g == 1) ? 13 : 14);
    logic [31:0] rdata;
    always @(posedge clk) rdata <= mem[mem_addr_a[g]];
    sha256_msg_padder #(.NUM_OF_WORDS(NW)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start_a[g]),
      .message_addr  (message_addr_a[g]),
      .mem_clk       (mem_clk_a[g]),
      .mem_addr      (mem_addr_a[g]),
      .mem_read_data (rdata),
      .blk_valid     (blk_valid_a[g]),
      .blk_ready     (blk_ready_a[g]),
      .blk_data      (blk_data_a[g]),
      .blk_last      (blk_last_a[g]),
      .blk_index     (blk_index_a[g]),
      .busy          (busy_a[g]),
      .done          (done_a[g])
    );
  end

  function automatic int nwords(input int g);
    return (g == 0) ? 20 : ((g == 1) ? 13 : 14);
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Padded block b of an n-word message at base, straight from the padding rules.
  function automatic logic [511:0] model_block(input int n, input logic [15:0] base, input int b);
    int nb;
    logic [511:0] blk;
    nb  = (n + 3 + 15) / 16;
    blk = '0;
    for (int s = 0; s < 16; s++) begin
      int w;
      logic [31:0] word;
      logic [15:0] a;
      w = b * 16 + s;
      a = 16'(32'(base) + 32'(w));
      if (w < n)                word = mem[a];
      else if (w == n)          word = 32'h8000_0000;
      else if (w == 16*nb - 1)  word = 32'(n * 32);
      else                      word = 32'h0;
      blk[511 - 32*s -: 32] = word;
    end
    return blk;
  endfunction

  task automatic check_reset_vals(input int g, input string tag);
    check($sformatf("%s g%0d valid", tag, g), 512'(blk_valid_a[g]), 512'(0));
    check($sformatf("%s g%0d data", tag, g),  blk_data_a[g],        512'(0));
    check($sformatf("%s g%0d index", tag, g), 512'(blk_index_a[g]), 512'(0));
    check($sformatf("%s g%0d last", tag, g),  512'(blk_last_a[g]),  512'(0));
    check($sformatf("%s g%0d addr", tag, g),  512'(mem_addr_a[g]),  512'(0));
    check($sformatf("%s g%0d busy", tag, g),  512'(busy_a[g]),      512'(0));
    check($sformatf("%s g%0d done", tag, g),  512'(done_a[g]),      512'(0));
  endtask

  // One message on instance g. stall_fix < 0 picks a random stall per block.
  task automatic run_msg(input int g, input logic [15:0] base, input int stall_fix,
                         input bit poke_start, input bit do_reset);
    int n, nb, t, stall, dn;
    logic [511:0] held_data;
    logic [7:0]   held_idx;
    logic         held_last;
    n  = nwords(g);
    nb = (n + 3 + 15) / 16;
    @(negedge clk);
    message_addr_a[g] = base;
    start_a[g]        = 1'b1;
    blk_ready_a[g]    = 1'($urandom_range(0, 1));
    @(negedge clk);
    start_a[g]        = 1'b0;
    message_addr_a[g] = 16'($urandom);
    check($sformatf("g%0d busy_on", g), 512'(busy_a[g]), 512'(1));
    for (int b = 0; b < nb; b++) begin
      t = 0;
      while (!blk_valid_a[g] && t < 40) begin
        if (do_reset && b == 1 && t == 7) begin
          reset = 1'b1;
          #1;
          check_reset_vals(g, "midreset");
          @(negedge clk);
          reset = 1'b0;
          dn = 0;
          repeat (40) begin
            @(negedge clk);
            dn += int'(done_a[g]);
          end
          check($sformatf("g%0d no_done_after_reset", g), 512'(dn), 512'(0));
          check($sformatf("g%0d idle_after_reset", g), 512'(busy_a[g]), 512'(0));
          return;
        end
        start_a[g]     = poke_start && b == 0 && (t == 3 || t == 4);
        blk_ready_a[g] = 1'($urandom_range(0, 1));
        @(negedge clk);
        t++;
      end
      start_a[g] = 1'b0;
      check($sformatf("g%0d b%0d latency", g, b), 512'(t), 512'(17));
      check($sformatf("g%0d b%0d data", g, b), blk_data_a[g], model_block(n, base, b));
      check($sformatf("g%0d b%0d index", g, b), 512'(blk_index_a[g]), 512'(b));
      check($sformatf("g%0d b%0d last", g, b), 512'(blk_last_a[g]), 512'(b == nb - 1));
      if (b == 0) first_blk = blk_data_a[g];
      last_blk  = blk_data_a[g];
      held_data = blk_data_a[g];
      held_idx  = blk_index_a[g];
      held_last = blk_last_a[g];
      stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 6));
      for (int i = 0; i < stall; i++) begin
        blk_ready_a[g] = 1'b0;
        @(negedge clk);
        check($sformatf("g%0d b%0d stall valid", g, b), 512'(blk_valid_a[g]), 512'(1));
        check($sformatf("g%0d b%0d stall data", g, b), blk_data_a[g], held_data);
        check($sformatf("g%0d b%0d stall index", g, b), 512'(blk_index_a[g]), 512'(held_idx));
        check($sformatf("g%0d b%0d stall last", g, b), 512'(blk_last_a[g]), 512'(held_last));
      end
      blk_ready_a[g] = 1'b1;
      @(negedge clk);
      blk_ready_a[g] = 1'($urandom_range(0, 1));
      check($sformatf("g%0d b%0d valid_drop", g, b), 512'(blk_valid_a[g]), 512'(0));
    end
    check($sformatf("g%0d done_early", g), 512'(done_a[g]), 512'(0));
    check($sformatf("g%0d busy_hold", g), 512'(busy_a[g]), 512'(1));
    @(negedge clk);
    check($sformatf("g%0d done_pulse", g), 512'(done_a[g]), 512'(1));
    check($sformatf("g%0d busy_at_done", g), 512'(busy_a[g]), 512'(1));
    @(negedge clk);
    check($sformatf("g%0d done_clear", g), 512'(done_a[g]), 512'(0));
    check($sformatf("g%0d busy_off", g), 512'(busy_a[g]), 512'(0));
    blk_ready_a[g] = 1'b0;
  endtask

  task automatic fill_random(input int n, input logic [15:0] base);
    for (int w = 0; w < n; w++) mem[16'(32'(base) + 32'(w))] = $urandom;
  endtask

  logic [511:0] exp_n20_b0;
  logic [511:0] exp_n20_b1;

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start_a[g]        = 1'b0;
      message_addr_a[g] = 16'h0;
      blk_ready_a[g]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) check_reset_vals(g, "por");
    reset = 1'b0;

    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
    for (int i = 0; i < 16; i++) exp_n20_b0[511 - 32*i -: 32] = 32'(i + 1);
    exp_n20_b1 = {32'd17, 32'd18, 32'd19, 32'd20, 32'h8000_0000, 288'h0, 32'h0, 32'h0000_0280};

    // N=20, base 0, ready mostly high.
    run_msg(0, 16'h0000, 0, 1'b0, 1'b0);
    check("n20 block0 const", first_blk, exp_n20_b0);
    check("n20 block1 const", last_blk, exp_n20_b1);

    // Backpressure of five cycles on every block.
    run_msg(0, 16'h0000, 5, 1'b0, 1'b0);
    check("n20 stall block1 const", last_blk, exp_n20_b1);

    // start pulsed during FILL of block 0 is ignored.
    run_msg(0, 16'h0000, 0, 1'b1, 1'b0);
    check("n20 poke block0 const", first_blk, exp_n20_b0);
    check("n20 poke block1 const", last_blk, exp_n20_b1);

    // Reset at FILL slot 7 of block 1, then a fresh identical run.
    run_msg(0, 16'h0000, 0, 1'b0, 1'b1);
    run_msg(0, 16'h0000, 0, 1'b0, 1'b0);
    check("n20 rerun block0 const", first_blk, exp_n20_b0);
    check("n20 rerun block1 const", last_blk, exp_n20_b1);

    // N=13: single block at base 0x0100.
    fill_random(13, 16'h0100);
    run_msg(1, 16'h0100, -1, 1'b0, 1'b0);
    check("n13 tail const", 512'(last_blk[95:0]), 512'({32'h8000_0000, 32'h0, 32'h0000_01A0}));

    // N=14 boundary: delimiter is the second-to-last word of block 0.
    fill_random(14, 16'h0200);
    run_msg(2, 16'h0200, -1, 1'b0, 1'b0);
    check("n14 block0 tail const", 512'(first_blk[63:0]), 512'(64'h8000_0000_0000_0000));
    check("n14 block1 const", last_blk, {480'h0, 32'h0000_01C0});

    // Randomized messages, bases (including address wrap) and backpressure.
    for (int k = 0; k < 9; k++) begin
      int g;
      logic [15:0] base;
      g    = int'($urandom_range(0, NI - 1));
      base = (k % 3 == 2) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
      fill_random(nwords(g), base);
      run_msg(g, base, -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
